effect_echo: RTL and testbench

Feedback echo effect: the processing stage between the controller's input FIFO and its output FIFO. Pops one 16-bit sample per handshake, mixes it with a scaled copy of its own output from `i_delay` samples earlier (circular delay RAM), saturates, and returns the result with a one-cycle valid pulse. Runs entirely in the main `clk` domain.

---
 rtl/effect_echo_pkg.sv | 24 ++
 rtl/effect_echo_if.sv | 25 ++
 rtl/effect_echo_delay_ram.sv | 29 ++
 rtl/effect_echo.sv | 130 +++++++++++++
 tb/tb_effect_echo.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/effect_echo_pkg.sv
// Shared definitions for the feedback echo stage: FSM encoding, default
// widths, gain fraction and saturation limits.
package effect_echo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;
    localparam int GAIN_W_DEF = 8;

    // Gain is unsigned Q0.8, so the product is scaled back by 8 bits.
    localparam int GAIN_FRAC = 8;

    // Saturation limits at the default sample width.
    localparam logic signed [DATA_W_DEF-1:0] MAX_S = 16'sh7FFF;
    localparam logic signed [DATA_W_DEF-1:0] MIN_S = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_MAC     = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

endpackage

// File: rtl/effect_echo_if.sv
// Sample stream bundle: pop handshake from the input FIFO and the
// write strobe/data toward the output FIFO.
interface effect_echo_if
    import effect_echo_pkg::*;
#(
    parameter int DW = DATA_W_DEF
);
    logic          i_data_valid;
    logic          o_read_enable;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_data;
    logic          o_dv;

    // The echo stage itself.
    modport slave (
        input  i_data_valid, i_data,
        output o_read_enable, o_data, o_dv
    );

    // The FIFO side / environment.
    modport master (
        output i_data_valid, i_data,
        input  o_read_enable, o_data, o_dv
    );
endinterface

// File: rtl/effect_echo_delay_ram.sv
// Circular delay line storage: one write port, one registered read port,
// both on the same clock. Contents are deliberately not cleared on reset.
module delay_ram #(
    parameter int addr_width = 12,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);
    logic [data_width-1:0] mem_q [2**addr_width];
    logic [data_width-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read; data appears the cycle after re_i.
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/effect_echo.sv
// Feedback echo: pops one sample, adds gain-scaled output from i_delay
// samples ago, saturates, writes the result back to the delay line and
// emits it with a one-cycle valid.
module effect_echo
    import effect_echo_pkg::*;
#(
    parameter int memory_d_width      = DATA_W_DEF,
    parameter int delay_address_width = ADDR_W_DEF,
    parameter int gain_width          = GAIN_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    effect_echo_if.slave                   bus,
    input  logic [delay_address_width-1:0] i_delay,
    input  logic [gain_width-1:0]          i_gain,
    input  logic                           i_bypass
);
    localparam int DW = memory_d_width;
    localparam int AW = delay_address_width;
    localparam int GW = gain_width;
    localparam int PW = DW + GW + 1;   // signed sample x {0,gain}
    localparam int SW = DW + 1;        // one headroom bit for the mix

    // Width-generic versions of MAX_S / MIN_S.
    localparam logic signed [DW-1:0] SAT_HI = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_LO = {1'b1, {(DW-1){1'b0}}};

    state_e                state_q;
    logic                  rd_en_q;
    logic                  dv_q;
    logic signed [DW-1:0]  y_q;
    logic signed [DW-1:0]  x_q;
    logic [GW-1:0]         gain_q;
    logic                  bypass_q;
    logic                  echo_en_q;
    logic signed [PW-1:0]  p_q;
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         fill_q;

    logic [AW-1:0]         rd_addr;
    logic                  echo_en_d;
    logic [DW-1:0]         ram_rdata;
    logic signed [DW-1:0]  d_s;
    logic signed [GW:0]    g_s;
    logic signed [PW-1:0]  p_d;
    logic signed [SW-1:0]  sum;
    logic signed [DW-1:0]  y_d;

    // Read address wraps naturally, keeping the echo continuous across
    // the write pointer wrap. Unwritten locations never feed back.
    assign rd_addr   = wr_ptr_q - i_delay;
    assign echo_en_d = (i_delay != '0) && (i_delay <= fill_q);

    delay_ram #(
        .addr_width (AW),
        .data_width (DW)
    ) u_ram (
        .clk     (clk),
        .we_i    (state_q == ST_OUT),
        .waddr_i (wr_ptr_q),
        .wdata_i (y_d),
        .re_i    (state_q == ST_CAPTURE),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // Multiply, scale, mix and saturate.
    always_comb begin
        d_s = ram_rdata;
        g_s = {1'b0, gain_q};
        p_d = echo_en_q ? (PW'(d_s) * PW'(g_s)) : '0;
        sum = SW'(x_q) + SW'(p_q >>> GAIN_FRAC);
        if (bypass_q)              y_d = x_q;
        else if (sum > SW'(SAT_HI)) y_d = SAT_HI;
        else if (sum < SW'(SAT_LO)) y_d = SAT_LO;
        else                        y_d = DW'(sum);
    end

    // Sample sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            dv_q      <= 1'b0;
            y_q       <= '0;
            x_q       <= '0;
            gain_q    <= '0;
            bypass_q  <= 1'b0;
            echo_en_q <= 1'b0;
            p_q       <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
        end else begin
            rd_en_q <= 1'b0;
            dv_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_data_valid) begin
                        state_q <= ST_POP;
                        rd_en_q <= 1'b1;
                    end
                end
                ST_POP: state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    x_q       <= bus.i_data;
                    gain_q    <= i_gain;
                    bypass_q  <= i_bypass;
                    echo_en_q <= echo_en_d;
                    state_q   <= ST_MAC;
                end
                ST_MAC: begin
                    p_q     <= p_d;
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    y_q      <= y_d;
                    dv_q     <= 1'b1;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (fill_q != {AW{1'b1}}) fill_q <= fill_q + 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_read_enable = rd_en_q;
    assign bus.o_dv          = dv_q;
    assign bus.o_data        = y_q;
endmodule

// File: tb/tb_effect_echo.sv
// Bench for effect_echo: fixed vector table, timing/reset sequences and a
// long randomized run against an output-history reference model.
module tb_effect_echo;
    import effect_echo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] i_delay;
    logic [7:0]  i_gain;
    logic        i_bypass;

    always #5 clk = ~clk;

    effect_echo_if #(.DW(16)) bus ();

    effect_echo dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .i_delay  (i_delay),
        .i_gain   (i_gain),
        .i_bypass (i_bypass)
    );

    int total = 0;
    int bad   = 0;
    int hist[$];   // every output since the last reset, oldest first

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: y[n] = sat(x + floor(y[n-delay]*gain/256)), echo only when
    // that older output exists since reset (history capped at 4095 deep).
    function automatic int model_step(int x, int dly, int g, bit byp);
        int n, fill, d, s;
        n    = hist.size();
        fill = (n > 4095) ? 4095 : n;
        d    = 0;
        if (dly != 0 && dly <= fill) d = hist[n - dly];
        s = x + ((d * g) >>> 8);
        if (byp) s = x;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        hist.push_back(s);
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.i_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hist.delete();
    endtask

    task automatic set_ctrl(input int dly, input int g, input bit byp);
        i_delay  = 12'(dly);
        i_gain   = 8'(g);
        i_bypass = byp;
    endtask

    // Acts as the input FIFO for one sample and waits for the result.
    task automatic run_sample(input int x, output int y, output bit ok);
        int n;
        ok = 1'b0;
        y  = 0;
        @(negedge clk);
        bus.i_data_valid = 1'b1;
        n = 0;
        while (!bus.o_read_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_read_enable) begin
            check("pop_timeout", 0, 1);
            bus.i_data_valid = 1'b0;
            return;
        end
        bus.i_data_valid = 1'b0;
        bus.i_data = 16'(x);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_dv && n < 20);
        if (!bus.o_dv) begin
            check("dv_timeout", 0, 1);
            return;
        end
        ok = 1'b1;
        y  = $signed(bus.o_data);
        check("dv_latency", n, 4);
    endtask

    // One sample with control settings, checked against the model.
    task automatic model_sample(input string name, input int x, input int dly,
                                input int g, input bit byp);
        int y, e;
        bit ok;
        set_ctrl(dly, g, byp);
        e = model_step(x, dly, g, byp);
        run_sample(x, y, ok);
        if (ok) check(name, y, e);
    endtask

    typedef struct {
        bit rst;
        int x;
        int dly;
        int g;
        bit byp;
        int exp;
    } vec_t;

    vec_t vt[$];
    bit   re_log[40];
    bit   dv_log[40];

    initial begin
        int y, e, f, cnt, dly;
        bit ok;

        reset = 1'b1;
        bus.i_data_valid = 1'b0;
        bus.i_data = '0;
        set_ctrl(0, 0, 0);

        do_reset();
        check("rst_dv", int'(bus.o_dv), 0);
        check("rst_re", int'(bus.o_read_enable), 0);
        check("rst_data", int'(bus.o_data), 0);

        // Impulse, no echo
        vt.push_back('{1, 1000, 0, 255, 0, 1000});
        for (int i = 0; i < 3; i++) vt.push_back('{0, 0, 0, 255, 0, 0});
        // Impulse, delay 4, half gain
        vt.push_back('{1, 16384, 4, 128, 0, 16384});
        for (int i = 1; i <= 8; i++)
            vt.push_back('{0, 0, 4, 128, 0, (i == 4) ? 8192 : (i == 8) ? 4096 : 0});
        // Positive / negative saturation with delay 1
        vt.push_back('{1, 30000, 1, 255, 0, 30000});
        vt.push_back('{0, 30000, 1, 255, 0, int'(MAX_S)});
        vt.push_back('{0, 30000, 1, 255, 0, int'(MAX_S)});
        vt.push_back('{1, -30000, 1, 255, 0, -30000});
        vt.push_back('{0, -30000, 1, 255, 0, int'(MIN_S)});
        vt.push_back('{0, -30000, 1, 255, 0, int'(MIN_S)});

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            set_ctrl(vt[i].dly, vt[i].g, vt[i].byp);
            void'(model_step(vt[i].x, vt[i].dly, vt[i].g, vt[i].byp));
            run_sample(vt[i].x, y, ok);
            if (ok) check($sformatf("vec%0d", i), y, vt[i].exp);
        end

        // Stale RAM contents must never echo: fill the whole line with
        // full scale, reset, then run with a long delay.
        do_reset();
        set_ctrl(0, 0, 0);
        for (int i = 0; i < 4096; i++) run_sample(32767, y, ok);
        do_reset();
        set_ctrl(100, 255, 0);
        for (int i = 0; i < 101; i++) begin
            run_sample(1, y, ok);
            if (ok) check("stale", y, 1);
        end

        // Back-to-back pops with valid held high
        do_reset();
        set_ctrl(0, 0, 0);
        bus.i_data = 16'd123;
        @(negedge clk);
        bus.i_data_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            re_log[c] = bus.o_read_enable;
            dv_log[c] = bus.o_dv;
        end
        f = -1;
        for (int c = 0; c < 40; c++) if (f < 0 && re_log[c]) f = c;
        check("first_pop", f, 0);
        if (f >= 0) begin
            for (int c = 0; c < 40; c++) begin
                check($sformatf("re_c%0d", c), int'(re_log[c]),
                      int'(c >= f && (c - f) % 5 == 0));
                check($sformatf("dv_c%0d", c), int'(dv_log[c]),
                      int'(c >= f + 4 && (c - f - 4) % 5 == 0));
            end
        end
        bus.i_data_valid = 1'b0;
        repeat (10) @(negedge clk);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cnt += int'(bus.o_read_enable) + int'(bus.o_dv);
        end
        check("idle_quiet", cnt, 0);

        // Reset during MAC discards the sample and clears the pointers
        do_reset();
        for (int i = 0; i < 5; i++) model_sample("pre_rst", 10000, 0, 0, 0);
        set_ctrl(4, 255, 0);
        @(negedge clk);
        bus.i_data_valid = 1'b1;
        cnt = 0;
        while (!bus.o_read_enable && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_pop", int'(bus.o_read_enable), 1);
        bus.i_data_valid = 1'b0;
        bus.i_data = 16'd5000;
        @(negedge clk);            // CAPTURE
        @(negedge clk);            // MAC
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cnt += int'(bus.o_dv);
        end
        check("mid_rst_dv", cnt, 0);
        check("mid_rst_data", int'(bus.o_data), 0);
        for (int i = 0; i < 4; i++) begin
            set_ctrl(4, 255, 0);
            void'(model_step(1000 + i, 4, 255, 0));
            run_sample(1000 + i, y, ok);
            if (ok) check("post_rst", y, 1000 + i);
        end
        for (int i = 0; i < 4; i++) model_sample("post_rst_echo", -2000, 4, 255, 0);
        for (int i = 0; i < 8; i++) begin
            set_ctrl(4, 255, 1);
            void'(model_step(3000 - i * 700, 4, 255, 1));
            run_sample(3000 - i * 700, y, ok);
            if (ok) check("bypass", y, 3000 - i * 700);
        end

        // Long randomized run, crossing the write pointer wrap
        do_reset();
        dly = 0;
        for (int i = 0; i < 4200; i++) begin
            int x, g;
            bit byp;
            if (i % 64 == 0) begin
                dly = $urandom_range(0, 9);
                if (dly == 9) dly = $urandom_range(0, 4095);
            end
            if ($urandom_range(0, 3) == 0)
                x = ($urandom_range(0, 1) != 0) ? 32767 - $urandom_range(0, 2000)
                                               : -32768 + $urandom_range(0, 2000);
            else
                x = $urandom_range(0, 65535) - 32768;
            g   = $urandom_range(0, 255);
            byp = ($urandom_range(0, 19) == 0);
            model_sample("rand", x, dly, g, byp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
